// File: rtl/map_bank_unit_pkg.sv
// Shared types, register-decode keys and save-state index map for the map_bank_unit mapper core.
package map_bank_unit_pkg;

    typedef enum logic {
        MIRR_VERT = 1'b0,
        MIRR_HORZ = 1'b1
    } mirr_e;

    // Write decode key is {A14, A13, A0} of a CPU write to $8000-$FFFF
    typedef logic [2:0] reg_key_t;

    localparam reg_key_t KEY_SEL        = 3'b000;
    localparam reg_key_t KEY_BANK       = 3'b001;
    localparam reg_key_t KEY_MIRR       = 3'b010;
    localparam reg_key_t KEY_WRAM       = 3'b011;
    localparam reg_key_t KEY_IRQ_LATCH  = 3'b100;
    localparam reg_key_t KEY_IRQ_RELOAD = 3'b101;
    localparam reg_key_t KEY_IRQ_DIS    = 3'b110;
    localparam reg_key_t KEY_IRQ_EN     = 3'b111;

    // Save-state slots that follow the bank registers
    localparam int unsigned SST_SEL_OFS  = 0;
    localparam int unsigned SST_CTRL_OFS = 1;
    localparam int unsigned SST_IRQ_OFS  = 2;
    localparam int unsigned SST_IRQ_REGS = 5;

    // IRQ slot order relative to the first IRQ slot
    localparam logic [2:0] IRQ_SST_LATCH_LO = 3'd0;
    localparam logic [2:0] IRQ_SST_LATCH_HI = 3'd1;
    localparam logic [2:0] IRQ_SST_COUNT_LO = 3'd2;
    localparam logic [2:0] IRQ_SST_COUNT_HI = 3'd3;
    localparam logic [2:0] IRQ_SST_CTRL     = 3'd4;

    typedef struct packed {
        logic       wram_en;
        logic       wram_wp;
        logic [4:0] rsvd;
        logic       mirr;
    } ctrl_byte_t;

    // Window index taken from the top 'bits' bits ending at 'msb'; 0 when there is a single window
    function automatic int unsigned win_idx(input logic [15:0] addr, input int unsigned msb,
                                            input int unsigned bits);
        return (32'(addr) >> (msb + 1 - bits)) & ((32'd1 << bits) - 32'd1);
    endfunction

endpackage

// File: rtl/map_bank_unit_if.sv
// Cart-side bus between CPU/PPU decode, the mapper core and the save-state controller.
interface map_bank_unit_if #(
    parameter int unsigned ADDR_BITS = 23
);
    logic                 m2;
    logic [15:0]          cpu_addr;
    logic [7:0]           cpu_data_in;
    logic                 cpu_rw;
    logic [13:0]          ppu_addr;
    logic [ADDR_BITS-1:0] prg_addr;
    logic                 prg_oe;
    logic                 prg_we;
    logic                 wram_ce;
    logic [ADDR_BITS-1:0] chr_addr;
    logic                 ciram_a10;
    logic                 irq;
    logic                 sst_enable;
    logic                 sst_we;
    logic [5:0]           sst_addr;
    logic [7:0]           sst_data_in;
    logic [7:0]           sst_data_out;

    modport master (
        output m2, cpu_addr, cpu_data_in, cpu_rw, ppu_addr,
        output sst_enable, sst_we, sst_addr, sst_data_in,
        input  prg_addr, prg_oe, prg_we, wram_ce, chr_addr, ciram_a10, irq, sst_data_out
    );

    modport slave (
        input  m2, cpu_addr, cpu_data_in, cpu_rw, ppu_addr,
        input  sst_enable, sst_we, sst_addr, sst_data_in,
        output prg_addr, prg_oe, prg_we, wram_ce, chr_addr, ciram_a10, irq, sst_data_out
    );

endinterface

// File: rtl/map_bank_unit_irq_counter.sv
// 16-bit CPU-cycle IRQ counter for map_bank_unit; only built when MAP_BANK_UNIT_IRQ_EN is defined.
`ifdef MAP_BANK_UNIT_IRQ_EN
module map_bank_unit_irq_counter
    import map_bank_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       wr,
    input  reg_key_t   key,
    input  logic       a1,
    input  logic [7:0] wdata,
    input  logic       sst_wr,
    input  logic [2:0] sst_idx,
    input  logic [7:0] sst_wdata,
    output logic [7:0] sst_rdata_c,
    output logic       irq
);

    logic [15:0] latch;
    logic [15:0] count;
    logic        irq_en;
    logic        pend;

    // Register writes are applied after the decrement so a coinciding reload or disable wins
    always_ff @(posedge clk) begin
        if (reset) begin
            latch  <= '0;
            count  <= '0;
            irq_en <= 1'b0;
            pend   <= 1'b0;
        end else begin
            if (tick && irq_en) begin
                if (count == 16'd0) begin
                    pend  <= 1'b1;
                    count <= latch;
                end else begin
                    count <= count - 16'd1;
                end
            end
            if (wr) begin
                case (key)
                    // A0 is taken by the reload register, so A1 picks the latch byte
                    KEY_IRQ_LATCH: begin
                        if (a1) latch[15:8] <= wdata;
                        else    latch[7:0]  <= wdata;
                    end
                    KEY_IRQ_RELOAD: count <= latch;
                    KEY_IRQ_DIS: begin
                        irq_en <= 1'b0;
                        pend   <= 1'b0;
                    end
                    KEY_IRQ_EN: irq_en <= 1'b1;
                    default: ;
                endcase
            end
            if (sst_wr) begin
                case (sst_idx)
                    IRQ_SST_LATCH_LO: latch[7:0]   <= sst_wdata;
                    IRQ_SST_LATCH_HI: latch[15:8]  <= sst_wdata;
                    IRQ_SST_COUNT_LO: count[7:0]   <= sst_wdata;
                    IRQ_SST_COUNT_HI: count[15:8]  <= sst_wdata;
                    IRQ_SST_CTRL: begin
                        irq_en <= sst_wdata[1];
                        pend   <= sst_wdata[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        sst_rdata_c = 8'h00;
        case (sst_idx)
            IRQ_SST_LATCH_LO: sst_rdata_c = latch[7:0];
            IRQ_SST_LATCH_HI: sst_rdata_c = latch[15:8];
            IRQ_SST_COUNT_LO: sst_rdata_c = count[7:0];
            IRQ_SST_COUNT_HI: sst_rdata_c = count[15:8];
            IRQ_SST_CTRL:     sst_rdata_c = {6'b0, irq_en, pend};
            default:          sst_rdata_c = 8'h00;
        endcase
    end

    assign irq = pend;

endmodule
`endif

// File: rtl/map_bank_unit.sv
// Parametrised bank-switch mapper core: register decode, PRG/CHR/WRAM address translation, save-state access.
// Define MAP_BANK_UNIT_IRQ_EN to build in the CPU-cycle IRQ counter.
module map_bank_unit
    import map_bank_unit_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 23,
    parameter int unsigned PRG_BANKS = 4,
    parameter int unsigned CHR_BANKS = 8
) (
    input  logic            clk,
    input  logic            reset,
    map_bank_unit_if.slave  bus
);

    localparam int unsigned NB   = PRG_BANKS + CHR_BANKS;
    localparam int unsigned IW   = $clog2(NB);
    localparam int unsigned PW   = $clog2(PRG_BANKS);
    localparam int unsigned CW   = $clog2(CHR_BANKS);
    localparam int unsigned POFS = 15 - PW;
    localparam int unsigned COFS = 13 - CW;
    localparam int unsigned AW1  = ADDR_BITS - 1;

    localparam logic [5:0] SST_SEL      = 6'(NB + SST_SEL_OFS);
    localparam logic [5:0] SST_CTRL     = 6'(NB + SST_CTRL_OFS);
    localparam logic [5:0] SST_IRQ_BASE = 6'(NB + SST_IRQ_OFS);
    localparam logic [5:0] SST_IRQ_END  = 6'(NB + SST_IRQ_OFS + SST_IRQ_REGS);

    logic [7:0] bank [NB];
    logic [3:0] sel;
    mirr_e      mirr;
    logic       wram_en;
    logic       wram_wp;
    logic       m2_q;

    logic                 cpu_wr_c;
    logic                 sst_wr_c;
    reg_key_t             key_c;
    logic                 irq_sel_c;
    logic [7:0]           irq_rd_c;
    logic [7:0]           sst_rd_c;
    ctrl_byte_t           ctrl_c;
    ctrl_byte_t           ctrl_w_c;
    int unsigned          p_idx_c;
    int unsigned          c_idx_c;
    logic [31:0]          rom_c;
    logic [31:0]          chr_c;
    logic                 rom_hit_c;
    logic                 wram_hit_c;
    logic [ADDR_BITS-1:0] prg_map_c;

    // One write event per CPU cycle, on the M2 falling edge; save-state access locks the CPU out
    assign cpu_wr_c  = m2_q && !bus.m2 && !bus.cpu_rw && !bus.sst_enable && bus.cpu_addr[15];
    assign sst_wr_c  = bus.sst_enable && bus.sst_we;
    assign key_c     = {bus.cpu_addr[14:13], bus.cpu_addr[0]};
    assign irq_sel_c = (bus.sst_addr >= SST_IRQ_BASE) && (bus.sst_addr < SST_IRQ_END);
    assign ctrl_w_c  = ctrl_byte_t'(bus.sst_data_in);

`ifdef MAP_BANK_UNIT_IRQ_EN
    logic       tick_c;
    logic [2:0] irq_idx_c;
    logic [5:0] irq_rel_c;

    assign tick_c    = m2_q && !bus.m2 && !bus.sst_enable;
    assign irq_rel_c = bus.sst_addr - SST_IRQ_BASE;
    assign irq_idx_c = irq_rel_c[2:0];

    map_bank_unit_irq_counter u_irq (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick_c),
        .wr          (cpu_wr_c && key_c[2]),
        .key         (key_c),
        .a1          (bus.cpu_addr[1]),
        .wdata       (bus.cpu_data_in),
        .sst_wr      (sst_wr_c && irq_sel_c),
        .sst_idx     (irq_idx_c),
        .sst_wdata   (bus.sst_data_in),
        .sst_rdata_c (irq_rd_c),
        .irq         (bus.irq)
    );
`else
    assign irq_rd_c = 8'h00;
    assign bus.irq  = 1'b0;
`endif

    // Address translation from the current inputs and bank registers
    always_comb begin
        p_idx_c    = win_idx(bus.cpu_addr, 14, PW);
        c_idx_c    = win_idx({2'b00, bus.ppu_addr}, 12, CW);
        rom_c      = (32'(bank[IW'(p_idx_c)]) << POFS)
                   | (32'(bus.cpu_addr) & ((32'd1 << POFS) - 32'd1));
        chr_c      = (32'(bank[IW'(PRG_BANKS + c_idx_c)]) << COFS)
                   | (32'(bus.ppu_addr) & ((32'd1 << COFS) - 32'd1));
        rom_hit_c  = bus.cpu_addr[15];
        wram_hit_c = (bus.cpu_addr[15:13] == 3'b011) && wram_en;
        prg_map_c  = wram_hit_c ? {1'b1, AW1'(32'(bus.cpu_addr[12:0]))} : {1'b0, AW1'(rom_c)};
    end

    always_comb begin
        ctrl_c   = '{wram_en: wram_en, wram_wp: wram_wp, rsvd: 5'b0, mirr: mirr};
        sst_rd_c = 8'h00;
        if (bus.sst_addr < 6'(NB)) begin
            sst_rd_c = bank[IW'(bus.sst_addr)];
        end else if (bus.sst_addr == SST_SEL) begin
            sst_rd_c = {4'b0, sel};
        end else if (bus.sst_addr == SST_CTRL) begin
            sst_rd_c = ctrl_c;
        end else if (irq_sel_c) begin
            sst_rd_c = irq_rd_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NB; i++) begin
                bank[i] <= 8'(i);
            end
            sel              <= 4'd0;
            mirr             <= MIRR_VERT;
            wram_en          <= 1'b0;
            wram_wp          <= 1'b0;
            m2_q             <= 1'b0;
            bus.prg_addr     <= '0;
            bus.prg_oe       <= 1'b0;
            bus.prg_we       <= 1'b0;
            bus.wram_ce      <= 1'b0;
            bus.chr_addr     <= '0;
            bus.ciram_a10    <= 1'b0;
            bus.sst_data_out <= 8'h00;
        end else begin
            m2_q <= bus.m2;
            if (cpu_wr_c) begin
                case (key_c)
                    KEY_SEL:  sel <= bus.cpu_data_in[3:0];
                    KEY_BANK: if (5'(sel) < 5'(NB)) bank[IW'(sel)] <= bus.cpu_data_in;
                    KEY_MIRR: mirr <= mirr_e'(bus.cpu_data_in[0]);
                    KEY_WRAM: begin
                        wram_en <= bus.cpu_data_in[7];
                        wram_wp <= bus.cpu_data_in[6];
                    end
                    default: ;
                endcase
            end
            if (sst_wr_c) begin
                if (bus.sst_addr < 6'(NB)) begin
                    bank[IW'(bus.sst_addr)] <= bus.sst_data_in;
                end else if (bus.sst_addr == SST_SEL) begin
                    sel <= bus.sst_data_in[3:0];
                end else if (bus.sst_addr == SST_CTRL) begin
                    wram_en <= ctrl_w_c.wram_en;
                    wram_wp <= ctrl_w_c.wram_wp;
                    mirr    <= mirr_e'(ctrl_w_c.mirr);
                end
            end
            bus.prg_addr     <= prg_map_c;
            bus.wram_ce      <= wram_hit_c;
            bus.prg_oe       <= bus.m2 && bus.cpu_rw && (rom_hit_c || wram_hit_c);
            bus.prg_we       <= bus.m2 && !bus.cpu_rw && wram_hit_c && !wram_wp;
            bus.chr_addr     <= bus.ppu_addr[13] ? '0 : ADDR_BITS'(chr_c);
            bus.ciram_a10    <= (mirr == MIRR_HORZ) ? bus.ppu_addr[11] : bus.ppu_addr[10];
            bus.sst_data_out <= sst_rd_c;
        end
    end

endmodule

// File: tb/tb_map_bank_unit.sv
// Directed self-checking bench for map_bank_unit (PRG_BANKS=4, CHR_BANKS=8, ADDR_BITS=23).
module tb_map_bank_unit;

    localparam int unsigned AB = 23;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    map_bank_unit_if #(.ADDR_BITS(AB)) bus ();

    map_bank_unit #(
        .ADDR_BITS (AB),
        .PRG_BANKS (4),
        .CHR_BANKS (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        bus.cpu_addr    = addr;
        bus.cpu_data_in = data;
        bus.cpu_rw      = 1'b0;
        bus.m2          = 1'b1;
        step();
        bus.m2 = 1'b0;
        step();
        bus.cpu_rw = 1'b1;
    endtask

    task automatic m2_pulse(input logic [15:0] addr);
        bus.cpu_addr = addr;
        bus.cpu_rw   = 1'b1;
        bus.m2       = 1'b1;
        step();
        bus.m2 = 1'b0;
        step();
    endtask

    task automatic sst_write(input logic [5:0] idx, input logic [7:0] data);
        bus.sst_enable  = 1'b1;
        bus.sst_we      = 1'b1;
        bus.sst_addr    = idx;
        bus.sst_data_in = data;
        step();
        bus.sst_we     = 1'b0;
        bus.sst_enable = 1'b0;
    endtask

    task automatic sst_check(input string tag, input logic [5:0] idx, input logic [7:0] exp);
        bus.sst_addr = idx;
        step();
        check(tag, 32'(bus.sst_data_out), 32'(exp));
    endtask

    logic [7:0] exp_bank [12];
    logic       irq_on;

    initial begin
`ifdef MAP_BANK_UNIT_IRQ_EN
        irq_on = 1'b1;
`else
        irq_on = 1'b0;
`endif
        reset           = 1'b1;
        bus.m2          = 1'b0;
        bus.cpu_addr    = 16'h0000;
        bus.cpu_data_in = 8'h00;
        bus.cpu_rw      = 1'b1;
        bus.ppu_addr    = 14'h0000;
        bus.sst_enable  = 1'b0;
        bus.sst_we      = 1'b0;
        bus.sst_addr    = 6'd0;
        bus.sst_data_in = 8'h00;
        step();
        step();
        check("rst_prg_addr", 32'(bus.prg_addr), 32'h0);
        check("rst_chr_addr", 32'(bus.chr_addr), 32'h0);
        check("rst_prg_oe", 32'(bus.prg_oe), 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        check("rst_sst_out", 32'(bus.sst_data_out), 32'h0);
        reset = 1'b0;

        // Identity PRG map
        bus.m2 = 1'b1; bus.cpu_addr = 16'h8000;
        step();
        check("prg_8000", 32'(bus.prg_addr), 32'h000000);
        check("prg_oe_rom", 32'(bus.prg_oe), 32'h1);
        bus.cpu_addr = 16'hE000;
        step();
        check("prg_e000", 32'(bus.prg_addr), 32'h006000);
        bus.m2 = 1'b0;
        step();

        // Identity CHR map, then bank 5 (CHR window 1) = $12
        bus.ppu_addr = 14'h0400;
        step();
        check("chr_0400_id", 32'(bus.chr_addr), 32'h001400);
        check("a10_vert_0400", 32'(bus.ciram_a10), 32'h1);
        cpu_write(16'h8000, 8'h05);
        cpu_write(16'h8001, 8'h12);
        step();
        check("chr_0400_b12", 32'(bus.chr_addr), 32'h004800);

        // Mirroring
        bus.ppu_addr = 14'h0800;
        step();
        check("a10_vert_0800", 32'(bus.ciram_a10), 32'h0);
        cpu_write(16'hA000, 8'h01);
        step();
        check("a10_horz_0800", 32'(bus.ciram_a10), 32'h1);
        bus.ppu_addr = 14'h0400;
        step();
        check("a10_horz_0400", 32'(bus.ciram_a10), 32'h0);

        // WRAM disabled, enabled, then write-protected
        bus.m2 = 1'b1; bus.cpu_addr = 16'h6123;
        step();
        check("wram_off_ce", 32'(bus.wram_ce), 32'h0);
        check("wram_off_oe", 32'(bus.prg_oe), 32'h0);
        bus.m2 = 1'b0;
        step();
        cpu_write(16'hA001, 8'h80);
        bus.cpu_addr = 16'h6123; bus.cpu_data_in = 8'h55; bus.cpu_rw = 1'b0; bus.m2 = 1'b1;
        step();
        check("wram_ce", 32'(bus.wram_ce), 32'h1);
        check("wram_we", 32'(bus.prg_we), 32'h1);
        check("wram_addr", 32'(bus.prg_addr), 32'h400123);
        check("wram_wr_oe", 32'(bus.prg_oe), 32'h0);
        bus.m2 = 1'b0;
        step();
        bus.cpu_rw = 1'b1;
        cpu_write(16'hA001, 8'hC0);
        bus.cpu_addr = 16'h6123; bus.cpu_rw = 1'b0; bus.m2 = 1'b1;
        step();
        check("wram_wp_we", 32'(bus.prg_we), 32'h0);
        check("wram_wp_ce", 32'(bus.wram_ce), 32'h1);
        bus.m2 = 1'b0;
        step();
        bus.cpu_rw = 1'b1; bus.m2 = 1'b1;
        step();
        check("wram_rd_oe", 32'(bus.prg_oe), 32'h1);
        bus.m2 = 1'b0;
        step();

        // Save-state access blocks CPU writes; sst write/read of bank 2
        bus.sst_enable = 1'b1;
        cpu_write(16'h8001, 8'hAA);
        bus.sst_enable = 1'b0;
        sst_check("sst_blocks_cpu", 6'd5, 8'h12);
        step();
        check("chr_after_block", 32'(bus.chr_addr), 32'h004800);
        sst_write(6'd2, 8'h7F);
        sst_check("sst_bank2", 6'd2, 8'h7F);
        bus.m2 = 1'b1; bus.cpu_addr = 16'hC000;
        step();
        check("prg_c000_7f", 32'(bus.prg_addr), 32'h0FE000);
        bus.m2 = 1'b0;
        step();
        sst_check("sst_sel", 6'd12, 8'h05);
        sst_check("sst_ctrl", 6'd13, 8'hC1);
        sst_check("sst_unmapped", 6'd63, 8'h00);

        // Out-of-range select leaves every bank untouched
        cpu_write(16'h8000, 8'h0D);
        cpu_write(16'h8001, 8'h99);
        sst_check("sst_sel_oor", 6'd12, 8'h0D);
        for (int i = 0; i < 12; i++) exp_bank[i] = 8'(i);
        exp_bank[2] = 8'h7F;
        exp_bank[5] = 8'h12;
        for (int i = 0; i < 12; i++) sst_check($sformatf("bank%0d_oor", i), 6'(i), exp_bank[i]);

        // IRQ counter: latch=3, reload, enable; fires on the 4th M2 fall
        cpu_write(16'hC000, 8'h03);
        cpu_write(16'hC001, 8'h00);
        cpu_write(16'hE001, 8'h00);
        for (int p = 1; p <= 4; p++) begin
            m2_pulse(16'h8000);
            check($sformatf("irq_pulse%0d", p), 32'(bus.irq), 32'((p == 4) && irq_on));
        end
        sst_check("sst_irq_latch", 6'd14, irq_on ? 8'h03 : 8'h00);
        sst_check("sst_irq_ctrl", 6'd18, irq_on ? 8'h03 : 8'h00);
        cpu_write(16'hE000, 8'h00);
        check("irq_cleared", 32'(bus.irq), 32'h0);

        // Reset coinciding with a write event
        cpu_write(16'h8000, 8'h00);
        bus.cpu_addr = 16'h8001; bus.cpu_data_in = 8'h44; bus.cpu_rw = 1'b0; bus.m2 = 1'b1;
        step();
        bus.m2 = 1'b0;
        reset  = 1'b1;
        step();
        reset      = 1'b0;
        bus.cpu_rw = 1'b1;
        for (int i = 0; i < 12; i++) sst_check($sformatf("bank%0d_rst", i), 6'(i), 8'(i));
        sst_check("sel_rst", 6'd12, 8'h00);
        sst_check("ctrl_rst", 6'd13, 8'h00);
        check("irq_rst", 32'(bus.irq), 32'h0);
        bus.m2 = 1'b1; bus.cpu_addr = 16'hC000;
        step();
        check("prg_c000_rst", 32'(bus.prg_addr), 32'h004000);
        bus.m2 = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
